// File: rtl/clock_period_meter_if.sv
// Monitored-clock bundle for clock_period_meter: the raw slow clock going in,
// and the recovered edge strobes and period/high-time measurements coming out.
interface clock_period_meter_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   mon_clk;
  logic                   rise_pulse;
  logic                   fall_pulse;
  logic [COUNT_WIDTH-1:0] period;
  logic [COUNT_WIDTH-1:0] high_time;
  logic [COUNT_WIDTH-1:0] period_avg;
  logic                   period_valid;
  logic                   locked;
  logic                   lost;

  // The meter: samples mon_clk, drives the measurements.
  modport master (
    input  mon_clk,
    output rise_pulse, fall_pulse, period, high_time, period_avg,
           period_valid, locked, lost
  );

  // The consumer: drives mon_clk, reads the measurements.
  modport slave (
    output mon_clk,
    input  rise_pulse, fall_pulse, period, high_time, period_avg,
           period_valid, locked, lost
  );
endinterface

// File: rtl/clock_period_meter.sv
// clock_period_meter: samples a slow clock (mon_clk) as data in the in_clk
// domain, recovers its edges and measures the rise-to-rise period and high
// time in in_clk cycles. Flags lock once the period is stable and loss once
// no rising edge has been seen for TIMEOUT cycles.
// Optional feature macro: CLOCK_PERIOD_METER_AVG_EN enables a 4-deep running
// average on period_avg; without it period_avg simply mirrors period.
module clock_period_meter #(
  parameter int COUNT_WIDTH  = 16,
  parameter int TIMEOUT      = 65535,
  parameter int LOCK_PERIODS = 4,
  parameter int TOL          = 2
) (
  input  logic                 in_clk,
  input  logic                 rst,
  clock_period_meter_if.master mif
);

  localparam int SW = $clog2(LOCK_PERIODS + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO   = COUNT_WIDTH'(0);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_C  = COUNT_WIDTH'(TIMEOUT);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_M1 = COUNT_WIDTH'(TIMEOUT - 1);
  localparam logic [COUNT_WIDTH:0]   TOL_C      = (COUNT_WIDTH + 1)'(TOL);
  localparam logic [SW-1:0]          STREAK_0   = SW'(0);
  localparam logic [SW-1:0]          STREAK_1   = SW'(1);
  localparam logic [SW-1:0]          LOCK_C     = SW'(LOCK_PERIODS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } state_e;

  logic                   sync1_r, sync2_r, sync3_r;
  logic                   rise_r, fall_r;
  logic [COUNT_WIDTH-1:0] cnt_r, hcnt_r, high_capt_r;
  logic                   fall_seen_r;
  state_e                 state_r, state_nx_s;
  logic [COUNT_WIDTH-1:0] period_r, period_nx_s;
  logic [COUNT_WIDTH-1:0] high_time_r, high_time_nx_s;
  logic                   valid_r, valid_nx_s;
  logic                   locked_r, locked_nx_s;
  logic                   lost_r, lost_nx_s;
  logic [SW-1:0]          streak_r, streak_nx_s;
  logic signed [COUNT_WIDTH:0] diff_s;
  logic [COUNT_WIDTH:0]   abs_s;
  logic                   in_tol_s;
  logic                   timeout_s;

  // Two-flop synchroniser plus history flop; edge strobes are registered.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync1_r <= mif.mon_clk;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      rise_r  <= sync2_r & ~sync3_r;
      fall_r  <= ~sync2_r & sync3_r;
    end
  end

  // Period counter restarts at 1 on every rise and parks at TIMEOUT.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (rise_r) begin
      cnt_r <= CNT_ONE;
    end else if (cnt_r != TIMEOUT_C) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // High-time counter, captured on the falling edge; fall_seen marks a clean period.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      hcnt_r      <= CNT_ZERO;
      high_capt_r <= CNT_ZERO;
      fall_seen_r <= 1'b0;
    end else begin
      if (rise_r) begin
        hcnt_r <= CNT_ONE;
      end else if (hcnt_r != CNT_MAX) begin
        hcnt_r <= hcnt_r + CNT_ONE;
      end else begin
        hcnt_r <= hcnt_r;
      end
      if (fall_r) begin
        high_capt_r <= hcnt_r;
      end else begin
        high_capt_r <= high_capt_r;
      end
      if (rise_r) begin
        fall_seen_r <= 1'b0;
      end else if (fall_r) begin
        fall_seen_r <= 1'b1;
      end else begin
        fall_seen_r <= fall_seen_r;
      end
    end
  end

  // Distance of the new period from the previous one; cnt saturates so no wrap.
  always_comb begin
    diff_s = $signed({1'b0, cnt_r}) - $signed({1'b0, period_r});
    if (diff_s[COUNT_WIDTH]) begin
      abs_s = -diff_s;
    end else begin
      abs_s = diff_s;
    end
    in_tol_s  = (abs_s <= TOL_C);
    // A rise in the same cycle pre-empts the timeout.
    timeout_s = (cnt_r == TIMEOUT_M1) && !rise_r;
  end

  // Next-state logic: arming, period reporting, lock streak and loss.
  always_comb begin
    state_nx_s     = state_r;
    period_nx_s    = period_r;
    high_time_nx_s = high_time_r;
    valid_nx_s     = 1'b0;
    locked_nx_s    = locked_r;
    lost_nx_s      = lost_r;
    streak_nx_s    = streak_r;
    if (rise_r) begin
      lost_nx_s = 1'b0;
      case (state_r)
        IDLE: begin
          state_nx_s = ARMED;
        end
        ARMED: begin
          if (fall_seen_r) begin
            period_nx_s    = cnt_r;
            high_time_nx_s = high_capt_r;
            valid_nx_s     = 1'b1;
            streak_nx_s    = STREAK_1;
            locked_nx_s    = (STREAK_1 >= LOCK_C);
            state_nx_s     = TRACK;
          end else begin
            state_nx_s = ARMED;
          end
        end
        TRACK: begin
          if (fall_seen_r) begin
            period_nx_s    = cnt_r;
            high_time_nx_s = high_capt_r;
            valid_nx_s     = 1'b1;
            if (in_tol_s) begin
              if (streak_r >= LOCK_C) begin
                streak_nx_s = streak_r;
              end else begin
                streak_nx_s = streak_r + STREAK_1;
              end
              locked_nx_s = locked_r | (streak_nx_s >= LOCK_C);
            end else begin
              streak_nx_s = STREAK_1;
              locked_nx_s = (STREAK_1 >= LOCK_C);
            end
          end else begin
            state_nx_s = TRACK;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end else if (timeout_s) begin
      lost_nx_s   = 1'b1;
      locked_nx_s = 1'b0;
      streak_nx_s = STREAK_0;
      state_nx_s  = IDLE;
    end else begin
      state_nx_s = state_r;
    end
  end

  // State and reported-measurement registers.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      period_r    <= CNT_ZERO;
      high_time_r <= CNT_ZERO;
      valid_r     <= 1'b0;
      locked_r    <= 1'b0;
      lost_r      <= 1'b0;
      streak_r    <= STREAK_0;
    end else begin
      state_r     <= state_nx_s;
      period_r    <= period_nx_s;
      high_time_r <= high_time_nx_s;
      valid_r     <= valid_nx_s;
      locked_r    <= locked_nx_s;
      lost_r      <= lost_nx_s;
      streak_r    <= streak_nx_s;
    end
  end

`ifdef CLOCK_PERIOD_METER_AVG_EN
  localparam int SUMW = COUNT_WIDTH + 2;

  logic [COUNT_WIDTH-1:0] hist_r [4];
  logic [2:0]             fill_r, fill_nx_s;
  logic [COUNT_WIDTH-1:0] avg_r, avg_nx_s;
  logic [SUMW-1:0]        sum_s;

  // Average over the window that includes the period being reported now.
  always_comb begin
    sum_s = SUMW'(cnt_r) + SUMW'(hist_r[0]) + SUMW'(hist_r[1]) + SUMW'(hist_r[2]);
    if (fill_r >= 3'd4) begin
      fill_nx_s = 3'd4;
    end else begin
      fill_nx_s = fill_r + 3'd1;
    end
    case (fill_nx_s)
      3'd1:    avg_nx_s = COUNT_WIDTH'(sum_s);
      3'd2:    avg_nx_s = COUNT_WIDTH'(sum_s >> 1);
      3'd3:    avg_nx_s = COUNT_WIDTH'(sum_s / SUMW'(3));
      default: avg_nx_s = COUNT_WIDTH'(sum_s >> 2);
    endcase
  end

  // History shift register; emptied on loss so the average restarts cleanly.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist_r[i] <= CNT_ZERO;
      fill_r <= 3'd0;
      avg_r  <= CNT_ZERO;
    end else if (timeout_s) begin
      for (int i = 0; i < 4; i++) hist_r[i] <= CNT_ZERO;
      fill_r <= 3'd0;
      avg_r  <= avg_r;
    end else if (valid_nx_s) begin
      hist_r[0] <= cnt_r;
      hist_r[1] <= hist_r[0];
      hist_r[2] <= hist_r[1];
      hist_r[3] <= hist_r[2];
      fill_r    <= fill_nx_s;
      avg_r     <= avg_nx_s;
    end else begin
      fill_r <= fill_r;
      avg_r  <= avg_r;
    end
  end

  assign mif.period_avg = avg_r;
`else
  assign mif.period_avg = period_r;
`endif

  assign mif.rise_pulse   = rise_r;
  assign mif.fall_pulse   = fall_r;
  assign mif.period       = period_r;
  assign mif.high_time    = high_time_r;
  assign mif.period_valid = valid_r;
  assign mif.locked       = locked_r;
  assign mif.lost         = lost_r;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: mon_clk is generated from in_clk
// negedges so every edge lands at a known cycle; period_valid events are
// logged by a monitor and checked against hand-computed tables.
module tb_clock_period_meter;
  localparam int CW = 16;
  localparam int TO = 2000;
  localparam int LP = 4;
  localparam int TL = 2;

  logic in_clk = 1'b0;
  logic rst    = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  clock_period_meter_if #(.COUNT_WIDTH(CW)) mif ();

  clock_period_meter #(
    .COUNT_WIDTH(CW), .TIMEOUT(TO), .LOCK_PERIODS(LP), .TOL(TL)
  ) dut (
    .in_clk(in_clk),
    .rst   (rst),
    .mif   (mif.master)
  );

  always #5 in_clk = ~in_clk;

  int   cyc = 0;
  int   last_rise_cyc = 0;
  int   lost_cyc = 0;
  logic lost_d = 1'b0;
  int   q_period[$];
  int   q_high[$];
  int   q_avg[$];
  logic q_locked[$];

  always @(negedge in_clk) begin
    cyc = cyc + 1;
    if (mif.period_valid === 1'b1) begin
      q_period.push_back(int'(mif.period));
      q_high.push_back(int'(mif.high_time));
      q_avg.push_back(int'(mif.period_avg));
      q_locked.push_back(mif.locked);
    end
    if (mif.rise_pulse === 1'b1) last_rise_cyc = cyc;
    if (mif.lost === 1'b1 && lost_d !== 1'b1) lost_cyc = cyc;
    lost_d = mif.lost;
  end

  task automatic clear_q;
    q_period.delete(); q_high.delete(); q_avg.delete(); q_locked.delete();
  endtask

  task automatic mon_cycle(input int hi, input int lo);
    mif.mon_clk = 1'b1;
    repeat (hi) @(negedge in_clk);
    mif.mon_clk = 1'b0;
    repeat (lo) @(negedge in_clk);
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    mif.mon_clk = 1'b0;
    repeat (3) @(negedge in_clk);
    rst = 1'b0;
    @(negedge in_clk);
  endtask

  task automatic test_reset;
    mif.mon_clk = 1'b0;
    repeat (2) @(negedge in_clk);
    #1;
    vectors++;
    if ({mif.rise_pulse, mif.fall_pulse, mif.period_valid, mif.locked, mif.lost} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 00000",
               {mif.rise_pulse, mif.fall_pulse, mif.period_valid, mif.locked, mif.lost});
    end
    vectors++;
    if (mif.period !== 16'd0) begin miscompares++; $display("FAIL reset_period: got %0d expected 0", mif.period); end
    vectors++;
    if (mif.high_time !== 16'd0) begin miscompares++; $display("FAIL reset_high: got %0d expected 0", mif.high_time); end
    vectors++;
    if (mif.period_avg !== 16'd0) begin miscompares++; $display("FAIL reset_avg: got %0d expected 0", mif.period_avg); end
    rst = 1'b0;
    @(negedge in_clk);
  endtask

  // 1250-cycle clock, 625 high: lock on the 5th rise (4th report).
  task automatic test_lock;
    logic exp_l;
    apply_reset; clear_q;
    repeat (6) mon_cycle(625, 625);
    #1;
    vectors++;
    if (q_period.size() != 5) begin miscompares++; $display("FAIL lock_count: got %0d expected 5", q_period.size()); end
    for (int i = 0; i < q_period.size() && i < 5; i++) begin
      exp_l = (i >= 3) ? 1'b1 : 1'b0;
      vectors++;
      if (q_period[i] !== 1250) begin miscompares++; $display("FAIL lock_period[%0d]: got %0d expected 1250", i, q_period[i]); end
      vectors++;
      if (q_high[i] !== 625) begin miscompares++; $display("FAIL lock_high[%0d]: got %0d expected 625", i, q_high[i]); end
      vectors++;
      if (q_locked[i] !== exp_l) begin miscompares++; $display("FAIL lock_locked[%0d]: got %b expected %b", i, q_locked[i], exp_l); end
    end
  endtask

  // Stop the clock low while locked, then restart.
  task automatic test_loss;
    int waited = 0;
    while (mif.lost !== 1'b1 && waited < TO + 100) begin
      @(negedge in_clk); #1; waited++;
    end
    vectors++;
    if (mif.lost !== 1'b1) begin miscompares++; $display("FAIL loss_lost: got %b expected 1 (timed out)", mif.lost); end
    vectors++;
    if (lost_cyc - last_rise_cyc != TO) begin
      miscompares++; $display("FAIL loss_delay: got %0d expected %0d", lost_cyc - last_rise_cyc, TO);
    end
    vectors++;
    if (mif.locked !== 1'b0) begin miscompares++; $display("FAIL loss_locked: got %b expected 0", mif.locked); end
    vectors++;
    if (mif.period !== 16'd1250) begin miscompares++; $display("FAIL loss_period_hold: got %0d expected 1250", mif.period); end
    vectors++;
    if (mif.high_time !== 16'd625) begin miscompares++; $display("FAIL loss_high_hold: got %0d expected 625", mif.high_time); end
    clear_q;
    mon_cycle(625, 625);
    #1;
    vectors++;
    if (mif.lost !== 1'b0) begin miscompares++; $display("FAIL restart_lost: got %b expected 0", mif.lost); end
    vectors++;
    if (q_period.size() != 0) begin miscompares++; $display("FAIL restart_first_valid: got %0d reports expected 0", q_period.size()); end
    mon_cycle(625, 625);
    #1;
    vectors++;
    if (q_period.size() != 1) begin miscompares++; $display("FAIL restart_second_valid: got %0d reports expected 1", q_period.size()); end
    else begin
      vectors++;
      if (q_period[0] !== 1250) begin miscompares++; $display("FAIL restart_period: got %0d expected 1250", q_period[0]); end
    end
  endtask

  // mon_clk stuck high: one arming rise, then loss TIMEOUT cycles later.
  task automatic test_stuck_high;
    int waited = 0;
    apply_reset; clear_q;
    mif.mon_clk = 1'b1;
    while (mif.lost !== 1'b1 && waited < TO + 100) begin
      @(negedge in_clk); #1; waited++;
    end
    vectors++;
    if (mif.lost !== 1'b1) begin miscompares++; $display("FAIL stuck_lost: got %b expected 1 (timed out)", mif.lost); end
    vectors++;
    if (lost_cyc - last_rise_cyc != TO) begin
      miscompares++; $display("FAIL stuck_delay: got %0d expected %0d", lost_cyc - last_rise_cyc, TO);
    end
    vectors++;
    if (q_period.size() != 0) begin miscompares++; $display("FAIL stuck_reports: got %0d expected 0", q_period.size()); end
    mif.mon_clk = 1'b0;
  endtask

  // 1250/1256 never locks; 1250/1251 locks.
  task automatic test_tolerance;
    int   exp_p;
    logic exp_l;
    apply_reset; clear_q;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) mon_cycle(625, 625); else mon_cycle(628, 628);
    end
    #1;
    vectors++;
    if (q_period.size() != 5) begin miscompares++; $display("FAIL tol_wide_count: got %0d expected 5", q_period.size()); end
    for (int i = 0; i < q_period.size() && i < 5; i++) begin
      exp_p = (i % 2 == 0) ? 1250 : 1256;
      vectors++;
      if (q_period[i] !== exp_p) begin miscompares++; $display("FAIL tol_wide_period[%0d]: got %0d expected %0d", i, q_period[i], exp_p); end
      vectors++;
      if (q_locked[i] !== 1'b0) begin miscompares++; $display("FAIL tol_wide_locked[%0d]: got %b expected 0", i, q_locked[i]); end
    end
    apply_reset; clear_q;
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0) mon_cycle(625, 625); else mon_cycle(625, 626);
    end
    #1;
    vectors++;
    if (q_period.size() != 6) begin miscompares++; $display("FAIL tol_narrow_count: got %0d expected 6", q_period.size()); end
    for (int i = 0; i < q_period.size() && i < 6; i++) begin
      exp_p = (i % 2 == 0) ? 1250 : 1251;
      exp_l = (i >= 3) ? 1'b1 : 1'b0;
      vectors++;
      if (q_period[i] !== exp_p) begin miscompares++; $display("FAIL tol_narrow_period[%0d]: got %0d expected %0d", i, q_period[i], exp_p); end
      vectors++;
      if (q_locked[i] !== exp_l) begin miscompares++; $display("FAIL tol_narrow_locked[%0d]: got %b expected %b", i, q_locked[i], exp_l); end
    end
  endtask

  // Asynchronous reset in mid-period while locked.
  task automatic test_reset_mid;
    mif.mon_clk = 1'b1;
    repeat (300) @(negedge in_clk);
    #2;
    rst = 1'b1;
    mif.mon_clk = 1'b0;
    #1;
    vectors++;
    if ({mif.rise_pulse, mif.fall_pulse, mif.period_valid, mif.locked, mif.lost} !== 5'b0) begin
      miscompares++;
      $display("FAIL midrst_flags: got %b expected 00000",
               {mif.rise_pulse, mif.fall_pulse, mif.period_valid, mif.locked, mif.lost});
    end
    vectors++;
    if (mif.period !== 16'd0) begin miscompares++; $display("FAIL midrst_period: got %0d expected 0", mif.period); end
    vectors++;
    if (mif.high_time !== 16'd0) begin miscompares++; $display("FAIL midrst_high: got %0d expected 0", mif.high_time); end
    vectors++;
    if (mif.period_avg !== 16'd0) begin miscompares++; $display("FAIL midrst_avg: got %0d expected 0", mif.period_avg); end
    repeat (3) @(negedge in_clk);
    rst = 1'b0;
    clear_q;
    mon_cycle(625, 625);
    #1;
    vectors++;
    if (q_period.size() != 0) begin miscompares++; $display("FAIL midrst_first_rise: got %0d reports expected 0", q_period.size()); end
    mon_cycle(625, 625);
    #1;
    vectors++;
    if (q_period.size() != 1) begin miscompares++; $display("FAIL midrst_second_rise: got %0d reports expected 1", q_period.size()); end
    else begin
      vectors++;
      if (q_period[0] !== 1250) begin miscompares++; $display("FAIL midrst_period_val: got %0d expected 1250", q_period[0]); end
    end
  endtask

  // One-cycle glitch 900 cycles after a normal rise, then clean periods.
  task automatic test_glitch;
    int   exp_p[7] = '{1250, 900, 350, 1250, 1250, 1250, 1250};
    int   exp_h[7] = '{625, 625, 1, 625, 625, 625, 625};
    logic exp_l[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset; clear_q;
    repeat (6) mon_cycle(625, 625);
    #1;
    vectors++;
    if (mif.locked !== 1'b1) begin miscompares++; $display("FAIL glitch_prelock: got %b expected 1", mif.locked); end
    clear_q;
    mon_cycle(625, 275);
    mon_cycle(1, 349);
    repeat (5) mon_cycle(625, 625);
    #1;
    vectors++;
    if (q_period.size() != 7) begin miscompares++; $display("FAIL glitch_count: got %0d expected 7", q_period.size()); end
    for (int i = 0; i < q_period.size() && i < 7; i++) begin
      vectors++;
      if (q_period[i] !== exp_p[i]) begin miscompares++; $display("FAIL glitch_period[%0d]: got %0d expected %0d", i, q_period[i], exp_p[i]); end
      vectors++;
      if (q_high[i] !== exp_h[i]) begin miscompares++; $display("FAIL glitch_high[%0d]: got %0d expected %0d", i, q_high[i], exp_h[i]); end
      vectors++;
      if (q_locked[i] !== exp_l[i]) begin miscompares++; $display("FAIL glitch_locked[%0d]: got %b expected %b", i, q_locked[i], exp_l[i]); end
    end
  endtask

  // Periods 1000/1004/1008/1012 and the averaged output.
  task automatic test_avg;
    int exp_p[4] = '{1000, 1004, 1008, 1012};
`ifdef CLOCK_PERIOD_METER_AVG_EN
    int exp_a[4] = '{1000, 1002, 1004, 1006};
`else
    int exp_a[4] = '{1000, 1004, 1008, 1012};
`endif
    apply_reset; clear_q;
    mon_cycle(500, 500);
    mon_cycle(502, 502);
    mon_cycle(504, 504);
    mon_cycle(506, 506);
    mif.mon_clk = 1'b1;
    repeat (20) @(negedge in_clk);
    mif.mon_clk = 1'b0;
    #1;
    vectors++;
    if (q_period.size() != 4) begin miscompares++; $display("FAIL avg_count: got %0d expected 4", q_period.size()); end
    for (int i = 0; i < q_period.size() && i < 4; i++) begin
      vectors++;
      if (q_period[i] !== exp_p[i]) begin miscompares++; $display("FAIL avg_period[%0d]: got %0d expected %0d", i, q_period[i], exp_p[i]); end
      vectors++;
      if (q_avg[i] !== exp_a[i]) begin miscompares++; $display("FAIL avg_value[%0d]: got %0d expected %0d", i, q_avg[i], exp_a[i]); end
    end
`ifndef CLOCK_PERIOD_METER_AVG_EN
    for (int c = 0; c < 40; c++) begin
      @(negedge in_clk); #1;
      vectors++;
      if (mif.period_avg !== mif.period) begin
        miscompares++; $display("FAIL avg_mirror[%0d]: got %0d expected %0d", c, mif.period_avg, mif.period);
      end
    end
`endif
  endtask

  initial begin
    mif.mon_clk = 1'b0;
    rst = 1'b1;
    test_reset;
    test_lock;
    test_loss;
    test_stuck_high;
    test_tolerance;
    test_reset_mid;
    test_glitch;
    test_avg;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
